// File: rtl/uart_prog_loader.sv
// UART program loader: parses a 4-byte little-endian length header, then turns
// each payload byte into a byte-addressed instruction-memory write while holding the CPU in reset.
module uart_prog_loader #(
  parameter int unsigned BYTE_ADDR_WIDTH = 6,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data_in,
  input  logic                       rx_valid_in,
  output logic [BYTE_ADDR_WIDTH-1:0] byte_addr_out,
  output logic [7:0]                 byte_data_out,
  output logic                       byte_wr_en_out,
  output logic                       cpu_rst_out,
  output logic                       busy_out,
  output logic                       done_out,
  output logic                       err_out
);

  localparam int unsigned CNT_W    = 32;
  localparam logic [32:0] CAPACITY = 33'(1) << BYTE_ADDR_WIDTH;
  localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES) - 32'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           len_q, len_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [CNT_W-1:0]           idle_q, idle_d;
  logic [1:0]                 hdr_q, hdr_d;
  logic [BYTE_ADDR_WIDTH-1:0] addr_d;
  logic [7:0]                 data_d;
  logic                       wr_d, done_d, err_d, busy_d;
  logic [CNT_W-1:0]           len_full;
  logic [CNT_W-1:0]           cnt_inc;
  logic                       in_range;
  logic                       timeout;

  // State register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      len_q          <= '0;
      cnt_q          <= '0;
      idle_q         <= '0;
      hdr_q          <= '0;
      byte_addr_out  <= '0;
      byte_data_out  <= '0;
      byte_wr_en_out <= 1'b0;
      cpu_rst_out    <= 1'b1;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      err_out        <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      idle_q         <= idle_d;
      hdr_q          <= hdr_d;
      byte_addr_out  <= addr_d;
      byte_data_out  <= data_d;
      byte_wr_en_out <= wr_d;
      cpu_rst_out    <= busy_d;
      busy_out       <= busy_d;
      done_out       <= done_d;
      err_out        <= err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    hdr_d    = hdr_q;
    addr_d   = byte_addr_out;
    data_d   = byte_data_out;
    wr_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    len_full = {rx_data_in, len_q[23:0]};
    cnt_inc  = cnt_q + 32'd1;
    in_range = ({1'b0, cnt_q} < CAPACITY);
    // Expiry is decided in the cycle the idle count would reach the limit; it beats a late byte.
    timeout  = TO_EN && ((state_q == LEN) || (state_q == DATA)) && (idle_q == TO_LAST);

    case (state_q)
      IDLE: begin
        if (rx_valid_in) begin
          len_d   = {24'd0, rx_data_in};
          hdr_d   = 2'd1;
          idle_d  = '0;
          state_d = LEN;
        end
      end

      LEN: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (rx_valid_in) begin
          idle_d = '0;
          len_d[{hdr_q, 3'b000} +: 8] = rx_data_in;
          hdr_d  = hdr_q + 2'd1;
          if (hdr_q == 2'd3) begin
            cnt_d = '0;
            if (len_full == '0) begin
              state_d = DONE;
            end else begin
              state_d = DATA;
            end
          end
        end else begin
          idle_d = TO_EN ? idle_q + 32'd1 : idle_q;
        end
      end

      DATA: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (rx_valid_in) begin
          idle_d = '0;
          cnt_d  = cnt_inc;
          // Bytes past the memory capacity are consumed but never written.
          if (in_range) begin
            wr_d   = 1'b1;
            addr_d = cnt_q[BYTE_ADDR_WIDTH-1:0];
            data_d = rx_data_in;
          end
          if (cnt_inc == len_q) begin
            state_d = DONE;
          end
        end else begin
          idle_d = TO_EN ? idle_q + 32'd1 : idle_q;
        end
      end

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // done_out is registered from the transition into DONE so it lines up with the last write.
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: stimulus pushes expected writes, pulses and
// output levels tagged with their cycle; a negedge monitor pops and compares them.
module tb_uart_prog_loader;

  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data_in;
  logic          rx_valid_in;
  logic [AW-1:0] byte_addr_out;
  logic [7:0]    byte_data_out;
  logic          byte_wr_en_out;
  logic          cpu_rst_out;
  logic          busy_out;
  logic          done_out;
  logic          err_out;

  uart_prog_loader #(
    .BYTE_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data_in    (rx_data_in),
    .rx_valid_in   (rx_valid_in),
    .byte_addr_out (byte_addr_out),
    .byte_data_out (byte_data_out),
    .byte_wr_en_out(byte_wr_en_out),
    .cpu_rst_out   (cpu_rst_out),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .err_out       (err_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  typedef struct {
    int            cyc;
    int            tag;
    logic          cpu_rst;
    logic          busy;
    bit            chk_addr;
    logic [AW-1:0] addr;
  } lvl_t;

  wr_t  exp_wr[$];
  int   exp_done[$];
  int   exp_err[$];
  lvl_t exp_lvl[$];

  int checks = 0;
  int errors = 0;
  bit drain_req  = 1'b0;
  bit drain_done = 1'b0;
  int tag_n = 0;

  // Monitor: every comparison of the run happens here
  always @(negedge clk) begin
    wr_t  w;
    lvl_t l;
    int   d;
    if (byte_wr_en_out) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc %0d: got addr %0d data %h, expected no write",
                 cyc, byte_addr_out, byte_data_out);
      end else begin
        w = exp_wr.pop_front();
        if (w.cyc != cyc || w.addr != byte_addr_out || w.data != byte_data_out) begin
          errors++;
          $display("FAIL write: got cyc %0d addr %0d data %h, expected cyc %0d addr %0d data %h",
                   cyc, byte_addr_out, byte_data_out, w.cyc, w.addr, w.data);
        end
      end
    end
    if (done_out) begin
      checks++;
      if (exp_done.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done_out=1 at cyc %0d, expected 0", cyc);
      end else begin
        d = exp_done.pop_front();
        if (d != cyc) begin
          errors++;
          $display("FAIL done_cycle: got cyc %0d, expected cyc %0d", cyc, d);
        end
      end
    end
    if (err_out) begin
      checks++;
      if (exp_err.size() == 0) begin
        errors++;
        $display("FAIL unexpected_err: got err_out=1 at cyc %0d, expected 0", cyc);
      end else begin
        d = exp_err.pop_front();
        if (d != cyc) begin
          errors++;
          $display("FAIL err_cycle: got cyc %0d, expected cyc %0d", cyc, d);
        end
      end
    end
    while (exp_lvl.size() > 0 && exp_lvl[0].cyc <= cyc) begin
      l = exp_lvl.pop_front();
      checks++;
      if (l.cyc != cyc) begin
        errors++;
        $display("FAIL level_missed tag %0d: checked at cyc %0d, expected cyc %0d", l.tag, cyc, l.cyc);
      end else if (cpu_rst_out !== l.cpu_rst || busy_out !== l.busy ||
                   (l.chk_addr && byte_addr_out !== l.addr)) begin
        errors++;
        $display("FAIL level tag %0d cyc %0d: got cpu_rst %b busy %b addr %0d, expected cpu_rst %b busy %b addr %0d",
                 l.tag, cyc, cpu_rst_out, busy_out, byte_addr_out, l.cpu_rst, l.busy, l.addr);
      end
    end
    if (drain_req && !drain_done) begin
      checks++;
      if (exp_wr.size() != 0 || exp_done.size() != 0 || exp_err.size() != 0 || exp_lvl.size() != 0) begin
        errors++;
        $display("FAIL leftover: got %0d writes %0d dones %0d errs %0d levels still pending, expected 0",
                 exp_wr.size(), exp_done.size(), exp_err.size(), exp_lvl.size());
      end
      drain_done = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one byte for one cycle, then stay idle for gap cycles.
  task automatic send(input logic [7:0] b, input int gap);
    rx_valid_in = 1'b1;
    rx_data_in  = b;
    tick();
    rx_valid_in = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic push_wr(input int c, input logic [AW-1:0] a, input logic [7:0] b);
    wr_t w;
    w.cyc  = c;
    w.addr = a;
    w.data = b;
    exp_wr.push_back(w);
  endtask

  task automatic push_lvl(input int c, input logic r, input logic b, input bit ca, input logic [AW-1:0] a);
    lvl_t l;
    l.cyc      = c;
    l.tag      = tag_n;
    l.cpu_rst  = r;
    l.busy     = b;
    l.chk_addr = ca;
    l.addr     = a;
    tag_n++;
    exp_lvl.push_back(l);
  endtask

  initial begin
    logic [7:0] pay4 [4];
    int c;
    pay4[0] = 8'hAA; pay4[1] = 8'hBB; pay4[2] = 8'hCC; pay4[3] = 8'hDD;

    // Reset and idle
    rst         = 1'b1;
    rx_valid_in = 1'b0;
    rx_data_in  = 8'h00;
    tick();
    tick();
    push_lvl(cyc, 1'b1, 1'b0, 1'b1, '0);
    rst = 1'b0;
    push_lvl(cyc + 1, 1'b0, 1'b0, 1'b1, '0);
    repeat (5) tick();
    push_lvl(cyc, 1'b0, 1'b0, 1'b1, '0);
    tick();

    // Four-byte upload with bytes spaced 3 cycles apart
    push_lvl(cyc + 1, 1'b1, 1'b1, 1'b0, '0);
    send(8'h04, 2);
    send(8'h00, 2);
    send(8'h00, 2);
    send(8'h00, 2);
    for (int k = 0; k < 4; k++) begin
      push_wr(cyc + 1, AW'(k), pay4[k]);
      if (k == 3) begin
        exp_done.push_back(cyc + 1);
        push_lvl(cyc + 1, 1'b1, 1'b1, 1'b0, '0);
        push_lvl(cyc + 2, 1'b0, 1'b0, 1'b0, '0);
      end
      send(pay4[k], 2);
    end
    repeat (2) tick();

    // Zero-length header; a byte arriving in DONE must be dropped
    send(8'h00, 2);
    send(8'h00, 2);
    send(8'h00, 2);
    exp_done.push_back(cyc + 1);
    push_lvl(cyc + 1, 1'b1, 1'b1, 1'b0, '0);
    push_lvl(cyc + 2, 1'b0, 1'b0, 1'b0, '0);
    push_lvl(cyc + 3, 1'b0, 1'b0, 1'b0, '0);
    push_lvl(cyc + 6, 1'b0, 1'b0, 1'b0, '0);
    send(8'h00, 0);
    send(8'h77, 6);

    // len=66 back-to-back: 64 writes, last two bytes overflow silently
    send(8'h42, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    for (int i = 0; i < 66; i++) begin
      if (i < 64) push_wr(cyc + 1, AW'(i), 8'(i + 16));
      if (i == 65) begin
        exp_done.push_back(cyc + 1);
        push_lvl(cyc + 2, 1'b0, 1'b0, 1'b0, '0);
      end
      send(8'(i + 16), 0);
    end
    repeat (3) tick();

    // Timeout: len=8, 3 payload bytes, then silence
    send(8'h08, 2);
    send(8'h00, 2);
    send(8'h00, 2);
    send(8'h00, 2);
    push_wr(cyc + 1, AW'(0), 8'h11);
    send(8'h11, 2);
    push_wr(cyc + 1, AW'(1), 8'h22);
    send(8'h22, 2);
    c = cyc + 1;
    push_wr(c, AW'(2), 8'h33);
    push_lvl(c + 19, 1'b1, 1'b1, 1'b0, '0);
    exp_err.push_back(c + 20);
    push_lvl(c + 20, 1'b0, 1'b0, 1'b0, '0);
    push_lvl(c + 24, 1'b0, 1'b0, 1'b0, '0);
    send(8'h33, 26);

    // Reset mid-upload, then a fresh one-byte upload
    send(8'h04, 2);
    send(8'h00, 2);
    send(8'h00, 2);
    send(8'h00, 2);
    push_wr(cyc + 1, AW'(0), 8'h91);
    send(8'h91, 2);
    push_wr(cyc + 1, AW'(1), 8'h92);
    send(8'h92, 1);
    rst = 1'b1;
    push_lvl(cyc, 1'b1, 1'b0, 1'b1, '0);
    tick();
    rst = 1'b0;
    push_lvl(cyc + 1, 1'b0, 1'b0, 1'b1, '0);
    tick();
    tick();
    push_lvl(cyc + 1, 1'b1, 1'b1, 1'b0, '0);
    send(8'h01, 1);
    send(8'h00, 1);
    send(8'h00, 1);
    send(8'h00, 1);
    push_wr(cyc + 1, AW'(0), 8'h5A);
    exp_done.push_back(cyc + 1);
    push_lvl(cyc + 2, 1'b0, 1'b0, 1'b0, '0);
    send(8'h5A, 4);

    drain_req = 1'b1;
    for (int i = 0; i < 5 && !drain_done; i++) tick();
    if (!drain_done) begin
      $display("FAIL drain: got monitor idle, expected final queue check");
      $fatal(1, "monitor did not drain");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached, expected end of stimulus");
    $fatal(1, "watchdog");
  end

endmodule
